// File: rtl/vtg_pkg.sv
// Shared definitions for the video timing core.
// Holds the default timing parameters and the FSM state type. It also holds the
// packed bundle of raw timing flags that travels down the sync/DE delay line,
// and the colour table for the optional vertical-bar test pattern.
// Optional feature macro: TEST_PATTERN_EN (see video_timing_core.sv).
package vtg_pkg;

    // Default 640x480@60 timing; the top takes these as parameter defaults.
    localparam int DEF_H_ACTIVE  = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_ACTIVE  = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_FETCH_LAT = 2;
    localparam int DEF_PIX_W     = 24;
    localparam int DEF_ADDR_W    = 21;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } vtg_state_e;

    // Raw timing flags, all active-high.
    // Sync polarity is applied only at the output register.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
        logic ls;
    } vtg_flags_t;

    // Eight vertical colour bars, left to right.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] colour;
        case (idx)
            3'd0:    colour = 24'hFFFFFF;
            3'd1:    colour = 24'hFFFF00;
            3'd2:    colour = 24'h00FFFF;
            3'd3:    colour = 24'h00FF00;
            3'd4:    colour = 24'hFF00FF;
            3'd5:    colour = 24'hFF0000;
            3'd6:    colour = 24'h0000FF;
            default: colour = 24'h000000;
        endcase
        return colour;
    endfunction

endpackage

// File: rtl/vtg_delay_line.sv
// Fixed-depth shift-register delay with an asynchronous active-low reset.
// On reset, every stage is loaded with RST_VAL.
// DEPTH=0 gives a plain wire-through, so the latency from din to dout is exactly DEPTH cycles.
// Ports:
//   clk   in  1  clock
//   rst_n in  1  async active-low reset
//   din   in  W  data in
//   dout  out W  data delayed by DEPTH cycles
module vtg_delay_line #(
    parameter int           W       = 1,
    parameter int           DEPTH   = 0,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_shift
            logic [W-1:0] stage_q [DEPTH];
            logic [W-1:0] stage_d [DEPTH];

            always_comb begin
                stage_d[0] = din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RST_VAL;
                    end
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= stage_d[i];
                    end
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing_core.sv
// Parametrised video timing and pixel-fetch generator.
// It runs in the pixel-clock domain and has three stages:
//   - A counter stage: hcnt and vcnt.
//   - Stage 1: rd_en and addr toward the framebuffer.
//   - An output register, which takes the raw sync, DE and strobes after a
//     FETCH_LAT delay line, so they line up with the pixel returned by the framebuffer.
// The latency from the counters to the outputs is FETCH_LAT+2 cycles.
// Optional macro TEST_PATTERN_EN: when defined, pix_out shows 8 vertical colour
// bars instead of pix_in, and rd_en stays low.
// Ports:
//   clk_low     in  1       pixel clock
//   reset_n     in  1       async active-low reset
//   en          in  1       run request, acted on only at frame boundaries
//   pix_in      in  PIX_W   framebuffer data, valid FETCH_LAT cycles after rd_en
//   rd_en       out 1       framebuffer read strobe
//   addr        out ADDR_W  linear framebuffer read address
//   pix_out     out PIX_W   pixel aligned to de, zero outside the active area
//   de          out 1       data enable
//   hsync       out 1       horizontal sync, HS_POL applied
//   vsync       out 1       vertical sync, VS_POL applied
//   frame_start out 1       pulse with the first active pixel of a frame
//   line_start  out 1       pulse with the first active pixel of each line
module video_timing_core
    import vtg_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int FETCH_LAT = DEF_FETCH_LAT,
    parameter int PIX_W     = DEF_PIX_W,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic              clk_low,
    input  logic              reset_n,
    input  logic              en,
    input  logic [PIX_W-1:0]  pix_in,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [PIX_W-1:0]  pix_out,
    output logic              de,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start,
    output logic              line_start
);

    localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    // One spare bit so that a sync end equal to the total still fits.
    localparam int HCNT_W = $clog2(HT + 1);
    localparam int VCNT_W = $clog2(VT + 1);

    localparam logic [HCNT_W-1:0] H_LAST   = HCNT_W'(HT - 1);
    localparam logic [VCNT_W-1:0] V_LAST   = VCNT_W'(VT - 1);
    localparam logic [HCNT_W-1:0] H_ACT_C  = HCNT_W'(H_ACTIVE);
    localparam logic [VCNT_W-1:0] V_ACT_C  = VCNT_W'(V_ACTIVE);
    localparam logic [HCNT_W-1:0] HS_BEG_C = HCNT_W'(HS_START);
    localparam logic [HCNT_W-1:0] HS_END_C = HCNT_W'(HS_END);
    localparam logic [VCNT_W-1:0] VS_BEG_C = VCNT_W'(VS_START);
    localparam logic [VCNT_W-1:0] VS_END_C = VCNT_W'(VS_END);

    localparam int FLAGS_W = $bits(vtg_flags_t);

    // A frame whose pixels do not all fit in the address space would alias silently.
    // So that configuration is refused at elaboration time.
    generate
        if (longint'(H_ACTIVE) * longint'(V_ACTIVE) > (longint'(1) << ADDR_W)) begin : g_addr_check
            $error("video_timing_core: H_ACTIVE*V_ACTIVE exceeds 2**ADDR_W");
        end
        if (FETCH_LAT < 0 || FETCH_LAT > 15) begin : g_lat_check
            $error("video_timing_core: FETCH_LAT must be in 0..15");
        end
    endgenerate

    vtg_state_e          state_q, state_d;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
    logic [VCNT_W-1:0]   vcnt_q, vcnt_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    vtg_flags_t          flags_q, flags_d;
    vtg_flags_t          flags_dl;
    logic                de_q, de_d;
    logic                hsync_q, hsync_d;
    logic                vsync_q, vsync_d;
    logic                fs_q, fs_d;
    logic                ls_q, ls_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [PIX_W-1:0]    pix_src;

    logic running;
    logic h_wrap;
    logic v_wrap;
    logic raw_active;

    assign running    = (state_q == RUN);
    assign h_wrap     = (hcnt_q == H_LAST);
    assign v_wrap     = (vcnt_q == V_LAST);
    assign raw_active = running && (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);

    // Run/idle FSM and raster counters.
    // Counters sit at zero while idle, so RUN always starts at the top-left pixel.
    // Leaving RUN is allowed only at the last pixel of a frame, so a frame is never cut short.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        case (state_q)
            IDLE: begin
                hcnt_d = '0;
                vcnt_d = '0;
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (h_wrap) begin
                    hcnt_d = '0;
                    if (v_wrap) begin
                        vcnt_d = '0;
                        if (!en) begin
                            state_d = IDLE;
                        end
                    end else begin
                        vcnt_d = vcnt_q + 1'b1;
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                hcnt_d  = '0;
                vcnt_d  = '0;
            end
        endcase
    end

    // Stage 1: read request and raw flag capture.
    // addr holds the index of the pixel being requested and advances after each read.
    // It returns to zero on the frame wrap, which also covers the RUN->IDLE transition.
    always_comb begin
`ifdef TEST_PATTERN_EN
        rd_en_d = 1'b0;
`else
        rd_en_d = raw_active;
`endif
        addr_d = addr_q;
        if (running && h_wrap && v_wrap) begin
            addr_d = '0;
        end else if (rd_en_q && (addr_q != '1)) begin
            addr_d = addr_q + 1'b1;
        end
        flags_d.hs = running && (hcnt_q >= HS_BEG_C) && (hcnt_q < HS_END_C);
        flags_d.vs = running && (vcnt_q >= VS_BEG_C) && (vcnt_q < VS_END_C);
        flags_d.de = raw_active;
        flags_d.fs = raw_active && (hcnt_q == '0) && (vcnt_q == '0);
        flags_d.ls = raw_active && (hcnt_q == '0);
    end

    // Counter stage and stage-1 registers.
    always_ff @(posedge clk_low or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            flags_q <= flags_d;
        end
    end

    // This delay matches the framebuffer read latency.
    // It keeps the flags in step with pix_in.
    vtg_delay_line #(
        .W       (FLAGS_W),
        .DEPTH   (FETCH_LAT),
        .RST_VAL ('0)
    ) u_flag_delay (
        .clk   (clk_low),
        .rst_n (reset_n),
        .din   (flags_q),
        .dout  (flags_dl)
    );

`ifdef TEST_PATTERN_EN
    // The bar colour is chosen at stage 1 and delayed like the flags.
    // This keeps the pattern timing identical to the framebuffer path.
    logic [PIX_W-1:0] bar_q, bar_d;
    logic [2:0]       bar_idx;

    always_comb begin
        bar_idx = 3'd7;
        if (raw_active) begin
            bar_idx = 3'((int'(hcnt_q) * 8) / H_ACTIVE);
        end
        bar_d = PIX_W'(bar_colour(bar_idx));
    end

    always_ff @(posedge clk_low or negedge reset_n) begin
        if (!reset_n) begin
            bar_q <= '0;
        end else begin
            bar_q <= bar_d;
        end
    end

    vtg_delay_line #(
        .W       (PIX_W),
        .DEPTH   (FETCH_LAT),
        .RST_VAL ('0)
    ) u_bar_delay (
        .clk   (clk_low),
        .rst_n (reset_n),
        .din   (bar_q),
        .dout  (pix_src)
    );
`else
    assign pix_src = pix_in;
`endif

    // Output register.
    // The pixel is gated by de, and sync polarity is applied only here.
    // All outputs therefore change on one clock edge, and no glitches occur at RUN/IDLE switches.
    always_comb begin
        de_d    = flags_dl.de;
        hsync_d = flags_dl.hs ? HS_POL : ~HS_POL;
        vsync_d = flags_dl.vs ? VS_POL : ~VS_POL;
        fs_d    = flags_dl.fs;
        ls_d    = flags_dl.ls;
        pix_d   = flags_dl.de ? pix_src : '0;
    end

    always_ff @(posedge clk_low or negedge reset_n) begin
        if (!reset_n) begin
            de_q    <= 1'b0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
            pix_q   <= '0;
        end else begin
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            fs_q    <= fs_d;
            ls_q    <= ls_d;
            pix_q   <= pix_d;
        end
    end

    assign rd_en       = rd_en_q;
    assign addr        = addr_q;
    assign pix_out     = pix_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;

endmodule
